// File: rtl/freq_divider_pkg.sv
// Project-wide frequency constants and helpers for deriving divider geometry.
package freq_divider_pkg;

    localparam int unsigned BOARD_CLK_HZ = 50_000_000;
    localparam int unsigned GAME_TICK_HZ = 5;

    // A zero output rate yields 0 so the divider's guard can reject it.
    function automatic int unsigned half_period(input int unsigned in_hz, input int unsigned out_hz);
        return (out_hz == 0) ? 0 : in_hz / (2 * out_hz);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned hp);
        return (hp <= 1) ? 1 : $clog2(hp);
    endfunction

endpackage

// File: rtl/freq_divider.sv
// Divides clk_in down to a 50% square wave and a one-cycle tick on each rising edge.
module freq_divider
    import freq_divider_pkg::*;
#(
    parameter int unsigned CLK_IN_HZ  = BOARD_CLK_HZ,
    parameter int unsigned CLK_OUT_HZ = GAME_TICK_HZ
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic en,
    output logic clk_out,
    output logic tick
);

    localparam int unsigned HALF_PERIOD = half_period(CLK_IN_HZ, CLK_OUT_HZ);
    localparam int unsigned CNT_W       = cnt_width(HALF_PERIOD);
    localparam logic [CNT_W-1:0] TOP    = CNT_W'(HALF_PERIOD - 1);

    if (CLK_OUT_HZ == 0 || HALF_PERIOD < 1) begin : g_bad_params
        $error("freq_divider: CLK_OUT_HZ must be nonzero and HALF_PERIOD at least 1");
    end

    logic [CNT_W-1:0] count;

    // tick takes the pre-toggle inverse so it only fires on the 0->1 transition.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (en) begin
            if (count == TOP) begin
                count   <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
            end else begin
                count <= count + 1'b1;
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_divider.sv
// Bench for freq_divider: HALF_PERIOD=5 and HALF_PERIOD=1 instances against a phase-arithmetic model.
module tb_freq_divider;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic clk_out5, tick5, clk_out1, tick1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: enabled edges since reset, and whether the last edge was an enabled one.
    int unsigned e = 0;
    bit last_en = 1'b0;

    always #5 clk = ~clk;

    freq_divider #(.CLK_IN_HZ(20), .CLK_OUT_HZ(2)) dut5 (
        .clk_in(clk), .rst_n(rst_n), .en(en), .clk_out(clk_out5), .tick(tick5)
    );

    freq_divider #(.CLK_IN_HZ(2), .CLK_OUT_HZ(1)) dut1 (
        .clk_in(clk), .rst_n(rst_n), .en(en), .clk_out(clk_out1), .tick(tick1)
    );

    function automatic logic exp_out(input int unsigned hp);
        return ((e % (2 * hp)) >= hp);
    endfunction

    function automatic logic exp_tick(input int unsigned hp);
        return last_en && ((e % (2 * hp)) == hp);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (e=%0d time=%0t)", tag, obs, expv, e, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " clk_out hp5"}, clk_out5, exp_out(5));
        chk({tag, " tick hp5"}, tick5, exp_tick(5));
        chk({tag, " clk_out hp1"}, clk_out1, exp_out(1));
        chk({tag, " tick hp1"}, tick1, exp_tick(1));
    endtask

    // One clock: model advances on the rising edge, outputs checked on the falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        last_en = rst_n && en;
        if (last_en) e++;
        @(negedge clk);
        check_all(tag);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        e = 0;
        last_en = 1'b0;
        #1;
        check_all({tag, " async"});
        @(negedge clk);
        check_all({tag, " held"});
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check_all("reset_hold");
        end

        rst_n = 1'b1;
        repeat (40) cycle("free_run");

        // Reach count=2 with clk_out=1 (phase 7), then gate for 7 cycles.
        for (int i = 0; i < 20 && (e % 10) != 7; i++) cycle("seek_gate");
        chk("gate_phase_reached", ((e % 10) == 7), 1'b1);
        en = 1'b0;
        repeat (7) cycle("en_gated");
        en = 1'b1;
        repeat (4) cycle("re_enabled");

        // Reach count=3 with clk_out=1 (phase 8), then reset mid-period.
        for (int i = 0; i < 20 && (e % 10) != 8; i++) cycle("seek_rst");
        chk("rst_phase_reached", ((e % 10) == 8), 1'b1);
        async_reset("mid_reset");
        repeat (12) cycle("post_reset");

        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(3, 0) != 0);
            if ($urandom_range(39, 0) == 0)
                async_reset("rand_reset");
            else
                cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
